// File: rtl/dma_periph_pkg.sv
// dma_periph_pkg: shared types and constants for the DMA I/O peripheral.
// The FSM state is one-hot. A compact state-index enum is kept alongside it
// for debug visibility. Optional build macro used by the peripheral top:
// DMA_PERIPH_SINGLE_MODE_EN.
package dma_periph_pkg;

    localparam int BYTE_W = 8;

    localparam logic DIR_DEV2MEM = 1'b0;
    localparam logic DIR_MEM2DEV = 1'b1;

    typedef enum logic [1:0] {
        IDLE_IDX    = 2'd0,
        REQ_IDX     = 2'd1,
        ACTIVE_IDX  = 2'd2,
        RELEASE_IDX = 2'd3
    } stateIdx_e;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        ACTIVE  = 4'b0100,
        RELEASE = 4'b1000
    } state_e;

    // Map a one-hot state onto its compact index for the debug port.
    function automatic stateIdx_e stateToIdx(input state_e s);
        case (s)
            REQ:     return REQ_IDX;
            ACTIVE:  return ACTIVE_IDX;
            RELEASE: return RELEASE_IDX;
            default: return IDLE_IDX;
        endcase
    endfunction

endpackage

// File: rtl/dma_io_peripheral_if.sv
// dma_io_peripheral_if: 8237-style DMA handshake and data bus between the
// controller (master) and an I/O device (slave).
// Handshake: the device holds DREQ while it wants service. The controller
// answers with DACK and then issues active-low nIOR/nIOW strobes. One byte
// moves per strobe. nEOP (active low, qualified by DACK) ends the transfer.
interface dma_io_peripheral_if;
    import dma_periph_pkg::*;

    logic              DREQ;
    logic              DACK;
    logic              nIOR;
    logic              nIOW;
    logic              nEOP;
    logic [BYTE_W-1:0] DataIn;
    logic [BYTE_W-1:0] DataOut;
    logic              DataOutEn;

    modport master (
        input  DREQ, DataOut, DataOutEn,
        output DACK, nIOR, nIOW, nEOP, DataIn
    );

    modport slave (
        output DREQ, DataOut, DataOutEn,
        input  DACK, nIOR, nIOW, nEOP, DataIn
    );

endinterface

// File: rtl/dma_byte_fifo.sv
// dma_byte_fifo: synchronous byte FIFO with one write port and one read port.
// The head byte is presented combinationally on RdData. A write into a full
// FIFO is dropped unless a read frees a slot in the same cycle. A read from
// an empty FIFO is ignored. LevelNext gives the occupancy after this cycle.
module dma_byte_fifo
    import dma_periph_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     WrEn,
    input  logic [BYTE_W-1:0]        WrData,
    input  logic                     RdEn,
    output logic [BYTE_W-1:0]        RdData,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Level,
    output logic [$clog2(DEPTH):0]   LevelNext
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [LW-1:0]     count;
    logic              doWr;
    logic              doRd;

    // Qualify requests against occupancy and work out the next level.
    always_comb begin
        Full      = (count == DEPTH_L);
        Empty     = (count == '0);
        doRd      = RdEn && !Empty;
        doWr      = WrEn && (!Full || doRd);
        LevelNext = count;
        if (doWr && !doRd) begin
            LevelNext = count + 1'b1;
        end else if (doRd && !doWr) begin
            LevelNext = count - 1'b1;
        end
        Level  = count;
        RdData = mem[rdPtr];
    end

    // Pointers and occupancy. Reset discards all contents.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            count <= LevelNext;
        end
    end

    // Storage array. It is not reset because the pointers define validity.
    always_ff @(posedge Clock) begin
        if (doWr) mem[wrPtr] <= WrData;
    end

endmodule

// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral: DMA target device for the 8237 handshake.
// It requests service when its FIFO crosses REQ_THRESH (bytes present for
// device-to-memory, bytes free for memory-to-device). It moves one byte per
// controller strobe and stops on FIFO empty/full or nEOP.
// Build option DMA_PERIPH_SINGLE_MODE_EN: after every byte, drop DREQ and
// go through RELEASE/IDLE before requesting again (single-transfer mode).
// Without it, DREQ is held until the FIFO is empty/full or nEOP (demand mode).
module dma_io_peripheral
    import dma_periph_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int REQ_THRESH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Dir,
    dma_io_peripheral_if.slave      bus,
    input  logic                    PushValid,
    input  logic [BYTE_W-1:0]       PushData,
    output logic                    PushReady,
    output logic                    PopValid,
    output logic [BYTE_W-1:0]       PopData,
    input  logic                    PopReady,
    output logic [$clog2(DEPTH):0]  Level,
    output logic                    Done,
    input  logic                    DoneClr,
    output logic [1:0]              StateDbg
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(REQ_THRESH);

    state_e            state;
    state_e            stateNext;
    logic              dirQ;
    logic              dirNext;
    logic              niorQ;
    logic              niowQ;
    logic              doneSet;
    logic              inActive;
    logic              busRd;
    logic              busWr;
    logic              xferEnd;
    logic              fifoWrEn;
    logic [BYTE_W-1:0] fifoWrData;
    logic              fifoRdEn;
    logic [BYTE_W-1:0] head;
    logic              full;
    logic              empty;
    logic [LW-1:0]     levelNext;

    dma_byte_fifo #(.DEPTH(DEPTH)) uFifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .WrEn      (fifoWrEn),
        .WrData    (fifoWrData),
        .RdEn      (fifoRdEn),
        .RdData    (head),
        .Full      (full),
        .Empty     (empty),
        .Level     (Level),
        .LevelNext (levelNext)
    );

    // Strobe edge detection and FIFO port muxing. A transfer needs DACK and
    // the other strobe inactive. The bus side owns a FIFO port only for the
    // latched direction. Otherwise the local producer/consumer drives it.
    always_comb begin
        inActive = (state == ACTIVE);
        busRd    = inActive && (dirQ == DIR_DEV2MEM) && bus.DACK &&
                   !niorQ && niowQ && bus.nIOR && bus.nIOW;
        busWr    = inActive && (dirQ == DIR_MEM2DEV) && bus.DACK &&
                   niowQ && !bus.nIOW && bus.nIOR;
        xferEnd  = (busRd && (levelNext == '0)) || (busWr && (levelNext == DEPTH_L));

        fifoWrEn   = PushValid;
        fifoWrData = PushData;
        if (dirQ == DIR_MEM2DEV && busWr) begin
            fifoWrEn   = 1'b1;
            fifoWrData = bus.DataIn;
        end
        fifoRdEn = PopReady;
        if (dirQ == DIR_DEV2MEM && busRd) begin
            fifoRdEn = 1'b1;
        end

        PushReady = !full;
        PopValid  = !empty;
        PopData   = head;
    end

    // State, latched direction and strobe history registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            dirQ  <= DIR_DEV2MEM;
            niorQ <= 1'b1;
            niowQ <= 1'b1;
        end else begin
            state <= stateNext;
            dirQ  <= dirNext;
            niorQ <= bus.nIOR;
            niowQ <= bus.nIOW;
        end
    end

    // Next-state logic. Direction is captured only when leaving IDLE.
    always_comb begin
        stateNext = state;
        dirNext   = dirQ;
        doneSet   = 1'b0;
        case (state)
            IDLE: begin
                if ((Dir == DIR_DEV2MEM && Level >= THRESH_L) ||
                    (Dir == DIR_MEM2DEV && (DEPTH_L - Level) >= THRESH_L)) begin
                    stateNext = REQ;
                    dirNext   = Dir;
                end
            end
            REQ: begin
                if (bus.DACK) stateNext = ACTIVE;
            end
            ACTIVE: begin
                if (!bus.nEOP && bus.DACK) begin
                    doneSet   = 1'b1;
                    stateNext = RELEASE;
`ifdef DMA_PERIPH_SINGLE_MODE_EN
                end else if (xferEnd || busRd || busWr) begin
                    stateNext = RELEASE;
`else
                end else if (xferEnd) begin
                    stateNext = RELEASE;
`endif
                end
            end
            RELEASE: begin
                if (!bus.DACK) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sticky completion flag. A set in the same cycle as a clear wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Done <= 1'b0;
        end else if (doneSet) begin
            Done <= 1'b1;
        end else if (DoneClr) begin
            Done <= 1'b0;
        end
    end

    // Bus-facing outputs decoded from state and live strobes.
    always_comb begin
        bus.DREQ      = (state == REQ) || (state == ACTIVE);
        bus.DataOutEn = inActive && (dirQ == DIR_DEV2MEM) && bus.DACK &&
                        !bus.nIOR && bus.nIOW;
        bus.DataOut   = (inActive && dirQ == DIR_DEV2MEM) ? head : '0;
        StateDbg      = stateToIdx(state);
    end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// tb_dma_io_peripheral: directed self-checking bench for dma_io_peripheral
// (DEPTH=16, REQ_THRESH=4). Inputs change 2 time units after each rising
// clock edge, and outputs are checked there or 1 unit later.
module tb_dma_io_peripheral;

    logic       Clock;
    logic       Reset;
    logic       Dir;
    logic       PushValid;
    logic [7:0] PushData;
    logic       PushReady;
    logic       PopValid;
    logic [7:0] PopData;
    logic       PopReady;
    logic [4:0] Level;
    logic       Done;
    logic       DoneClr;
    logic [1:0] StateDbg;
    int         total;
    int         bad;

    dma_io_peripheral_if busIf();

    dma_io_peripheral #(.DEPTH(16), .REQ_THRESH(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Dir       (Dir),
        .bus       (busIf),
        .PushValid (PushValid),
        .PushData  (PushData),
        .PushReady (PushReady),
        .PopValid  (PopValid),
        .PopData   (PopData),
        .PopReady  (PopReady),
        .Level     (Level),
        .Done      (Done),
        .DoneClr   (DoneClr),
        .StateDbg  (StateDbg)
    );

    // Clock generation.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    task automatic idle_inputs();
        busIf.DACK = 1'b0; busIf.nIOR = 1'b1; busIf.nIOW = 1'b1; busIf.nEOP = 1'b1;
        busIf.DataIn = 8'h00; PushValid = 1'b0; PushData = 8'h00; PopReady = 1'b0;
        DoneClr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        PushValid = 1'b1;
        PushData  = b;
        cyc();
        PushValid = 1'b0;
    endtask

    task automatic rd_pulse();
        busIf.nIOR = 1'b0;
        cyc();
        busIf.nIOR = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        Dir = 1'b1; PushValid = 1'b1; PushData = 8'hEE;
        Reset = 1'b1;
        cyc();
        cyc();
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL reset_dreq got=%0h exp=0", busIf.DREQ); end
        total++; if (busIf.DataOutEn !== 1'b0) begin bad++; $display("FAIL reset_oe got=%0h exp=0", busIf.DataOutEn); end
        total++; if (busIf.DataOut !== 8'h00) begin bad++; $display("FAIL reset_dout got=%0h exp=0", busIf.DataOut); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", Done); end
        total++; if (Level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", Level); end
        total++; if (PushReady !== 1'b1) begin bad++; $display("FAIL reset_pushready got=%0h exp=1", PushReady); end
        total++; if (PopValid !== 1'b0) begin bad++; $display("FAIL reset_popvalid got=%0h exp=0", PopValid); end
        total++; if (StateDbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", StateDbg); end
        Dir = 1'b0;
        do_reset();
    endtask

    task automatic test_dev2mem();
        logic [7:0] exp;
        do_reset();
        Dir = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL d2m_dreq_latency got=%0h exp=0", busIf.DREQ); end
        total++; if (Level !== 5'd4) begin bad++; $display("FAIL d2m_level4 got=%0d exp=4", Level); end
        cyc();
        total++; if (busIf.DREQ !== 1'b1) begin bad++; $display("FAIL d2m_dreq_up got=%0h exp=1", busIf.DREQ); end
        busIf.DACK = 1'b1;
        cyc();
        total++; if (StateDbg !== 2'd2) begin bad++; $display("FAIL d2m_active got=%0d exp=2", StateDbg); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h11 + 8'(i);
            busIf.nIOR = 1'b0;
            #1;
            total++; if (busIf.DataOutEn !== 1'b1) begin bad++; $display("FAIL d2m_oe_%0d got=%0h exp=1", i, busIf.DataOutEn); end
            total++; if (busIf.DataOut !== exp) begin bad++; $display("FAIL d2m_dout_%0d got=%0h exp=%0h", i, busIf.DataOut, exp); end
            cyc();
            busIf.nIOR = 1'b1;
            #1;
            total++; if (busIf.DataOutEn !== 1'b0) begin bad++; $display("FAIL d2m_oe_off_%0d got=%0h exp=0", i, busIf.DataOutEn); end
            cyc();
            if (i == 2) begin
                total++; if (busIf.DREQ !== 1'b1) begin bad++; $display("FAIL d2m_dreq_held got=%0h exp=1", busIf.DREQ); end
            end
        end
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL d2m_dreq_drop got=%0h exp=0", busIf.DREQ); end
        total++; if (Level !== 5'd0) begin bad++; $display("FAIL d2m_level0 got=%0d exp=0", Level); end
        total++; if (StateDbg !== 2'd3) begin bad++; $display("FAIL d2m_release got=%0d exp=3", StateDbg); end
        busIf.DACK = 1'b0;
        cyc();
        total++; if (StateDbg !== 2'd0) begin bad++; $display("FAIL d2m_idle got=%0d exp=0", StateDbg); end
    endtask

    task automatic test_mem2dev();
        logic [7:0] exp;
        do_reset();
        Dir = 1'b1;
        cyc();
        total++; if (busIf.DREQ !== 1'b1) begin bad++; $display("FAIL m2d_dreq_up got=%0h exp=1", busIf.DREQ); end
        busIf.DACK = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            busIf.DataIn = 8'hA0 + 8'(i);
            busIf.nIOW = 1'b0;
            cyc();
            busIf.nIOW = 1'b1;
            cyc();
            if (i == 14) begin
                total++; if (busIf.DREQ !== 1'b1) begin bad++; $display("FAIL m2d_dreq_held got=%0h exp=1", busIf.DREQ); end
            end
        end
        total++; if (Level !== 5'd16) begin bad++; $display("FAIL m2d_level16 got=%0d exp=16", Level); end
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL m2d_dreq_drop got=%0h exp=0", busIf.DREQ); end
        total++; if (PushReady !== 1'b0) begin bad++; $display("FAIL m2d_full got=%0h exp=0", PushReady); end
        busIf.DACK = 1'b0;
        PopReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 8'hA0 + 8'(i);
            total++; if (PopData !== exp || PopValid !== 1'b1) begin bad++; $display("FAIL m2d_pop_%0d got=%0h/%0h exp=%0h/1", i, PopData, PopValid, exp); end
            cyc();
        end
        PopReady = 1'b0;
        total++; if (Level !== 5'd0) begin bad++; $display("FAIL m2d_drained got=%0d exp=0", Level); end
    endtask

    task automatic test_eop();
        do_reset();
        Dir = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        busIf.DACK = 1'b1;
        cyc();
        rd_pulse();
        rd_pulse();
        busIf.nIOR = 1'b0;
        cyc();
        busIf.nIOR = 1'b1;
        busIf.nEOP = 1'b0;
        cyc();
        busIf.nEOP = 1'b1;
        total++; if (Done !== 1'b1) begin bad++; $display("FAIL eop_done got=%0h exp=1", Done); end
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL eop_dreq got=%0h exp=0", busIf.DREQ); end
        total++; if (Level !== 5'd5) begin bad++; $display("FAIL eop_level got=%0d exp=5", Level); end
        total++; if (PopData !== 8'h33) begin bad++; $display("FAIL eop_head got=%0h exp=33", PopData); end
        DoneClr = 1'b1;
        cyc();
        DoneClr = 1'b0;
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL eop_doneclr got=%0h exp=0", Done); end
    endtask

    task automatic test_ignored_strobes();
        do_reset();
        Dir = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        busIf.nIOR = 1'b0;
        #1;
        total++; if (busIf.DataOutEn !== 1'b0) begin bad++; $display("FAIL ign_oe_nodack got=%0h exp=0", busIf.DataOutEn); end
        cyc();
        busIf.nIOR = 1'b1;
        busIf.nEOP = 1'b0;
        cyc();
        busIf.nEOP = 1'b1;
        total++; if (Level !== 5'd5) begin bad++; $display("FAIL ign_level_req got=%0d exp=5", Level); end
        total++; if (Done !== 1'b0 || StateDbg !== 2'd1) begin bad++; $display("FAIL ign_eop_nodack got=%0h/%0d exp=0/1", Done, StateDbg); end
        busIf.DACK = 1'b1;
        cyc();
        busIf.nIOR = 1'b0;
        busIf.nIOW = 1'b0;
        #1;
        total++; if (busIf.DataOutEn !== 1'b0) begin bad++; $display("FAIL ign_oe_both got=%0h exp=0", busIf.DataOutEn); end
        cyc();
        busIf.nIOR = 1'b1;
        busIf.nIOW = 1'b1;
        cyc();
        total++; if (Level !== 5'd5) begin bad++; $display("FAIL ign_level_both got=%0d exp=5", Level); end
        busIf.DACK = 1'b0;
        rd_pulse();
        total++; if (Level !== 5'd5) begin bad++; $display("FAIL ign_level_active_nodack got=%0d exp=5", Level); end
        busIf.DACK = 1'b1;
        busIf.nIOR = 1'b0;
        cyc();
        cyc();
        cyc();
        busIf.nIOR = 1'b1;
        cyc();
        total++; if (Level !== 5'd4) begin bad++; $display("FAIL ign_wide_strobe got=%0d exp=4", Level); end
        total++; if (PopData !== 8'h51) begin bad++; $display("FAIL ign_wide_head got=%0h exp=51", PopData); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Dir = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h70 + 8'(i));
        busIf.DACK = 1'b1;
        cyc();
        rd_pulse();
        rd_pulse();
        total++; if (Level !== 5'd4) begin bad++; $display("FAIL rst_mid_level_pre got=%0d exp=4", Level); end
        Reset = 1'b1;
        cyc();
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL rst_mid_dreq got=%0h exp=0", busIf.DREQ); end
        total++; if (Level !== 5'd0) begin bad++; $display("FAIL rst_mid_level got=%0d exp=0", Level); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%0h exp=0", Done); end
        total++; if (StateDbg !== 2'd0) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", StateDbg); end
        Reset = 1'b0;
        busIf.DACK = 1'b0;
        cyc();
    endtask

    task automatic test_single_mode();
        do_reset();
        Dir = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            total++; if (busIf.DREQ !== 1'b1) begin bad++; $display("FAIL single_dreq_up_%0d got=%0h exp=1", i, busIf.DREQ); end
            busIf.DACK = 1'b1;
            cyc();
            busIf.nIOR = 1'b0;
            #1;
            total++; if (busIf.DataOut !== 8'h60 + 8'(i)) begin bad++; $display("FAIL single_dout_%0d got=%0h exp=%0h", i, busIf.DataOut, 8'h60 + 8'(i)); end
            cyc();
            busIf.nIOR = 1'b1;
            cyc();
            total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL single_dreq_drop_%0d got=%0h exp=0", i, busIf.DREQ); end
            busIf.DACK = 1'b0;
            cyc();
            cyc();
        end
        total++; if (busIf.DREQ !== 1'b0) begin bad++; $display("FAIL single_dreq_final got=%0h exp=0", busIf.DREQ); end
        total++; if (Level !== 5'd3) begin bad++; $display("FAIL single_level got=%0d exp=3", Level); end
    endtask

    // Test sequence and final report.
    initial begin
        total = 0;
        bad   = 0;
        Dir   = 1'b0;
        Reset = 1'b1;
        idle_inputs();
        test_reset();
`ifdef DMA_PERIPH_SINGLE_MODE_EN
        test_single_mode();
`else
        test_dev2mem();
        test_mem2dev();
        test_eop();
        test_ignored_strobes();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
